booth_mul_seq: RTL

Sequential signed 32×32 → 64-bit multiplier using radix-2 Booth recoding, one recoding step per clock. It is the multiply counterpart to the datapath divider and sits beside the ALU. It produces the full product as HI/LO words for the register file's HI/LO pair. Operands are captured on a start handshake, and the result is held stable until the next accepted start.

---
 rtl/booth_mul_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// Sequential signed WIDTHxWIDTH multiplier, radix-2 Booth recoding, one step per clock.
// Full product is presented as hi/lo words and held until the next completion or reset.
module booth_mul_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             ovf
);

   localparam int unsigned AW = WIDTH + 1;
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [AW-1:0]    m_q, m_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             qm1_q, qm1_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             ovf_q, ovf_d;
   logic [AW-1:0]    sum;

   // State and datapath registers
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         m_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state, Booth step and result capture
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      m_d     = m_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      ovf_d   = ovf_q;
      sum     = acc_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               m_d     = {a[WIDTH-1], a};
               acc_d   = '0;
               q_d     = b;
               qm1_d   = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            case ({q_q[0], qm1_q})
               2'b01:   sum = acc_q + m_q;
               2'b10:   sum = acc_q - m_q;
               default: sum = acc_q;
            endcase
            // Arithmetic shift of {A, Q, q-1}; the extra A bit keeps A - M from overflowing
            acc_d = {sum[AW-1], sum[AW-1:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               hi_d    = acc_d[WIDTH-1:0];
               lo_d    = q_d;
               ovf_d   = (acc_d[WIDTH-1:0] != {WIDTH{q_d[WIDTH-1]}});
            end else begin
               busy_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign ovf  = ovf_q;

endmodule
